// File: rtl/octal_key_pkg.sv
// Shared definitions for the octal key capture front end: FSM state
// encoding, code width and one-hot helper functions.
package octal_key_pkg;

  localparam int ONEHOT_W = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESENT  = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  // True when exactly one bit of v is set.
  function automatic logic is_onehot(input logic [ONEHOT_W-1:0] v);
    return (v != '0) && ((v & (v - ONEHOT_W'(1))) == '0);
  endfunction

  // Isolates the lowest-index set bit of v (zero stays zero).
  function automatic logic [ONEHOT_W-1:0] lowest_set(input logic [ONEHOT_W-1:0] v);
    return v & (~v + ONEHOT_W'(1));
  endfunction

endpackage

// File: rtl/octal_key_capture_if.sv
// Output handshake bundle between the key capture front end (master) and
// the octal-to-binary encoder (slave).
interface octal_key_capture_if;

  logic [octal_key_pkg::ONEHOT_W-1:0] onehot_data;
  logic                               onehot_valid;
  logic                               onehot_ready;
  logic                               multi_err;

  modport master (
    output onehot_data,
    output onehot_valid,
    output multi_err,
    input  onehot_ready
  );

  modport slave (
    input  onehot_data,
    input  onehot_valid,
    input  multi_err,
    output onehot_ready
  );

endinterface

// File: rtl/key_sync2.sv
// Two-flop synchroniser for asynchronous key lines; resets to all zeros.
module key_sync2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two register stages to settle metastability before the FSM sees the keys.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/octal_key_capture.sv
// Octal key capture: synchronises and debounces 8 key lines and emits one
// one-hot code per press under a valid/ready handshake.
// Build option: define PRIORITY_RESOLVE_EN to resolve a stable multi-key
// press to its lowest-index key instead of rejecting it with multi_err.
module octal_key_capture
  import octal_key_pkg::*;
#(
  parameter  int DEBOUNCE_CYCLES = 16,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ONEHOT_W-1:0]   key_raw,
  octal_key_capture_if.master   bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [ONEHOT_W-1:0] key_s;
  logic [ONEHOT_W-1:0] sample;
  logic [CNT_W-1:0]    cnt;
  logic [ONEHOT_W-1:0] data_q;
  logic                valid_q;
  logic                err_q;
  state_t              state;

  key_sync2 #(.W(ONEHOT_W)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (key_raw),
    .q     (key_s)
  );

  // Debounce/qualify FSM; the counter tracks stable presses in DEBOUNCE and
  // stable release cycles in WAIT_REL, and never exceeds CNT_MAX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sample  <= '0;
      cnt     <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (key_s != '0) begin
            sample <= key_s;
            cnt    <= '0;
            state  <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (key_s == '0) begin
            state <= IDLE;
          end else if (key_s != sample) begin
            sample <= key_s;
            cnt    <= '0;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
          end else begin
            cnt <= '0;
            if (is_onehot(sample)) begin
              data_q  <= sample;
              valid_q <= 1'b1;
              state   <= PRESENT;
            end else begin
`ifdef PRIORITY_RESOLVE_EN
              data_q  <= lowest_set(sample);
              valid_q <= 1'b1;
              state   <= PRESENT;
`else
              err_q   <= 1'b1;
              state   <= WAIT_REL;
`endif
            end
          end
        end
        PRESENT: begin
          // Valid is always high here; key release does not retract the code.
          if (bus.onehot_ready) begin
            valid_q <= 1'b0;
            cnt     <= '0;
            state   <= WAIT_REL;
          end
        end
        WAIT_REL: begin
          if (key_s != '0) begin
            cnt <= '0;
          end else if (cnt == CNT_MAX) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.onehot_data  = data_q;
  assign bus.onehot_valid = valid_q;
  assign bus.multi_err    = err_q;

endmodule
